// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared dispatch widths, FSM state and limiter encodings
package dispatch_pkg;

  localparam int WAY = 3;
  localparam int CNT_W = $clog2(WAY + 1);
  localparam int DEF_RECOVER_CYCLES = 2;

  typedef enum logic [1:0] {
    DS_RUN,
    DS_RECOVER,
    DS_HALTED
  } dispatch_state_e;

  typedef enum logic [1:0] {
    LIM_NONE,
    LIM_ROB,
    LIM_OTHER
  } limit_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [WAY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WAY; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// rtl/dispatch_if.sv - decode-slot, resource-count and grant bundle for dispatch_ctrl
interface dispatch_if;
  import dispatch_pkg::*;

  logic             squash;
  logic [WAY-1:0]   inst_valid;
  logic [WAY-1:0]   inst_wr_dest;
  logic [WAY-1:0]   inst_is_store;
  logic [WAY-1:0]   inst_is_halt;
  logic [CNT_W-1:0] rob_can;
  logic [CNT_W-1:0] rs_free;
  logic [CNT_W-1:0] fl_free;
  logic [CNT_W-1:0] sq_free;
  logic [WAY-1:0]   dispatch_en;
  logic [CNT_W-1:0] num_dispatched;
  logic             fetch_stall;
  logic             halted;

  modport master (
    output squash, inst_valid, inst_wr_dest, inst_is_store, inst_is_halt,
    output rob_can, rs_free, fl_free, sq_free,
    input  dispatch_en, num_dispatched, fetch_stall, halted
  );

  modport slave (
    input  squash, inst_valid, inst_wr_dest, inst_is_store, inst_is_halt,
    input  rob_can, rs_free, fl_free, sq_free,
    output dispatch_en, num_dispatched, fetch_stall, halted
  );

endinterface

// File: rtl/dispatch_grant.sv
// rtl/dispatch_grant.sv - combinational in-order prefix grant and stall-limiter encoder
module dispatch_grant
  import dispatch_pkg::*;
(
  input  logic [WAY-1:0]   valid,
  input  logic [WAY-1:0]   wr_dest,
  input  logic [WAY-1:0]   is_store,
  input  logic [WAY-1:0]   is_halt,
  input  logic [CNT_W-1:0] rob_can,
  input  logic [CNT_W-1:0] rs_free,
  input  logic [CNT_W-1:0] fl_free,
  input  logic [CNT_W-1:0] sq_free,
  output logic [WAY-1:0]   grant,
  output limit_e           limit
);

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] st_cnt;
  logic [CNT_W-1:0] idx;
  logic             chain;
  logic             halt_seen;
  logic             rob_ok;
  logic             res_ok;
  logic             ok;

  always_comb begin
    grant     = '0;
    limit     = LIM_NONE;
    wr_cnt    = '0;
    st_cnt    = '0;
    idx       = '0;
    chain     = 1'b1;
    halt_seen = 1'b0;
    rob_ok    = 1'b0;
    res_ok    = 1'b0;
    ok        = 1'b0;
    for (int i = 0; i < WAY; i++) begin
      idx    = CNT_W'(i);
      wr_cnt = wr_cnt + CNT_W'(wr_dest[i]);
      st_cnt = st_cnt + CNT_W'(is_store[i]);
      rob_ok = idx < rob_can;
      res_ok = (idx < rs_free) && (wr_cnt <= fl_free) && (st_cnt <= sq_free);
      ok     = chain && valid[i] && !halt_seen && rob_ok && res_ok;
      grant[i] = ok;
      // Only the first ungranted slot names the limiter; halt and invalid slots name none.
      if (chain && !ok && valid[i] && !halt_seen)
        limit = rob_ok ? LIM_OTHER : LIM_ROB;
      chain     = ok;
      halt_seen = halt_seen | is_halt[i];
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - dispatch scheduler: run/recover/halt FSM, grant masking, stall counters
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int PERF_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  dispatch_if.slave         dif,
  output logic [PERF_W-1:0] stall_rob_cnt,
  output logic [PERF_W-1:0] stall_other_cnt
);

  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES - 1);

  dispatch_state_e state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [WAY-1:0]  grant;
  logic [WAY-1:0]  en;
  limit_e          limit;
  logic            perf_hit;

  dispatch_grant u_grant (
    .valid    (dif.inst_valid),
    .wr_dest  (dif.inst_wr_dest),
    .is_store (dif.inst_is_store),
    .is_halt  (dif.inst_is_halt),
    .rob_can  (dif.rob_can),
    .rs_free  (dif.rs_free),
    .fl_free  (dif.fl_free),
    .sq_free  (dif.sq_free),
    .grant    (grant),
    .limit    (limit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DS_RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      DS_RUN: begin
        if (dif.squash) begin
          state_d = DS_RECOVER;
          rcnt_d  = RC_LOAD;
        end else if (|(en & dif.inst_is_halt)) begin
          state_d = DS_HALTED;
        end
      end
      DS_RECOVER: begin
        if (dif.squash)
          rcnt_d = RC_LOAD;
        else if (rcnt_q == '0)
          state_d = DS_RUN;
        else
          rcnt_d = rcnt_q - RC_W'(1);
      end
      DS_HALTED: begin
        // The dispatched HALT was on a wrong path; recover like any squash.
        if (dif.squash) begin
          state_d = DS_RECOVER;
          rcnt_d  = RC_LOAD;
        end
      end
      default: state_d = DS_RUN;
    endcase
  end

  always_comb begin
    en = '0;
    if (state_q == DS_RUN && !dif.squash) en = grant;
    dif.dispatch_en    = en;
    dif.num_dispatched = popcount(en);
    dif.fetch_stall    = (state_q == DS_RUN) && (|dif.inst_valid) &&
                         (popcount(en) < popcount(dif.inst_valid));
    dif.halted         = (state_q == DS_HALTED);
  end

  assign perf_hit = (state_q == DS_RUN) && dif.fetch_stall && !dif.squash;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_rob_cnt   <= '0;
      stall_other_cnt <= '0;
    end else if (perf_hit) begin
      if (limit == LIM_ROB && stall_rob_cnt != '1)
        stall_rob_cnt <= stall_rob_cnt + PERF_W'(1);
      if (limit == LIM_OTHER && stall_other_cnt != '1)
        stall_other_cnt <= stall_other_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - scoreboard bench for dispatch_ctrl with a behavioural reference model
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;
  localparam int RC  = 2;

  typedef struct {
    logic [2:0]    en;
    logic [1:0]    num;
    logic          fs;
    logic          hl;
    logic [PW-1:0] rc;
    logic [PW-1:0] oc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [PW-1:0] rob_cnt, oth_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  int m_state = 0;
  int m_cnt   = 0;
  int m_rob   = 0;
  int m_oth   = 0;

  dispatch_if dif ();

  dispatch_ctrl #(.RECOVER_CYCLES(RC), .PERF_W(PW)) dut (
    .clock           (clock),
    .reset           (reset),
    .dif             (dif.slave),
    .stall_rob_cnt   (rob_cnt),
    .stall_other_cnt (oth_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic sq, input logic [2:0] v, input logic [2:0] wd,
                      input logic [2:0] st, input logic [2:0] ht,
                      input int rob, input int rs, input int fl, input int sqf,
                      input int want_en);
    int lead, g, reason, wr, s, pc;
    bit hs, blocked, stop, run, halt_hit;
    exp_t e, o;
    dif.squash = sq; dif.inst_valid = v; dif.inst_wr_dest = wd;
    dif.inst_is_store = st; dif.inst_is_halt = ht;
    dif.rob_can = 2'(rob); dif.rs_free = 2'(rs); dif.fl_free = 2'(fl); dif.sq_free = 2'(sqf);

    lead = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      if (!stop && v[i]) lead++; else stop = 1;
    end
    g = 0; reason = 0; wr = 0; s = 0; hs = 0; blocked = 0; halt_hit = 0;
    for (int i = 0; i < 3; i++) begin
      wr += wd[i]; s += st[i];
      if (!blocked) begin
        if (i < lead && !hs && i < rob && i < rs && wr <= fl && s <= sqf) begin
          g++;
          if (ht[i]) halt_hit = 1;
        end else begin
          blocked = 1;
          if (i < lead && !hs) reason = (i >= rob) ? 1 : 2;
        end
      end
      if (ht[i]) hs = 1;
    end
    run = (m_state == 0) && !sq;
    pc = $countones(v);
    e.en  = run ? 3'((1 << g) - 1) : 3'b000;
    e.num = run ? 2'(g) : 2'd0;
    e.fs  = (m_state == 0) && (v != 0) && (int'(e.num) < pc);
    e.hl  = (m_state == 2);
    e.rc  = PW'(m_rob);
    e.oc  = PW'(m_oth);
    sb.push_back(e);

    @(negedge clock);
    o = sb.pop_front();
    chk("dispatch_en", 32'(dif.dispatch_en), 32'(o.en));
    chk("num_dispatched", 32'(dif.num_dispatched), 32'(o.num));
    chk("fetch_stall", 32'(dif.fetch_stall), 32'(o.fs));
    chk("halted", 32'(dif.halted), 32'(o.hl));
    chk("stall_rob_cnt", 32'(rob_cnt), 32'(o.rc));
    chk("stall_other_cnt", 32'(oth_cnt), 32'(o.oc));
    if (want_en >= 0) chk("directed_en", 32'(dif.dispatch_en), 32'(want_en));

    if (m_state == 0 && e.fs && !sq) begin
      if (reason == 1 && m_rob < SAT) m_rob++;
      if (reason == 2 && m_oth < SAT) m_oth++;
    end
    case (m_state)
      0: if (sq) begin m_state = 1; m_cnt = RC - 1; end
         else if (halt_hit) m_state = 2;
      1: if (sq) m_cnt = RC - 1;
         else if (m_cnt == 0) m_state = 0;
         else m_cnt--;
      default: if (sq) begin m_state = 1; m_cnt = RC - 1; end
    endcase
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.squash = 0; dif.inst_valid = 0; dif.inst_wr_dest = 0;
    dif.inst_is_store = 0; dif.inst_is_halt = 0;
    dif.rob_can = 0; dif.rs_free = 0; dif.fl_free = 0; dif.sq_free = 0;
    #12;
    chk("reset_en", 32'(dif.dispatch_en), 0);
    chk("reset_halted", 32'(dif.halted), 0);
    chk("reset_rob_cnt", 32'(rob_cnt), 0);
    chk("reset_oth_cnt", 32'(oth_cnt), 0);
    @(negedge clock); reset = 0;
    @(posedge clock); #1;

    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b111);
    step(0, 3'b111, 3'b111, 3'b000, 3'b000, 3, 3, 1, 3, 3'b001);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 2, 3, 3, 3, 3'b011);
    step(0, 3'b111, 3'b000, 3'b110, 3'b000, 3, 3, 3, 1, 3'b011);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 0, 3, 3, 3'b000);
    step(0, 3'b101, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b001);
    // halt in slot 1, then lockout, squash, two bubbles, run
    step(0, 3'b111, 3'b000, 3'b000, 3'b010, 3, 3, 3, 3, 3'b011);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(1, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b111);
    // squash with full resources, then re-squash on first bubble
    step(1, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(1, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    step(0, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b111);

    // async reset in the middle of a recovery bubble
    step(1, 3'b111, 3'b000, 3'b000, 3'b000, 3, 3, 3, 3, 3'b000);
    dif.squash = 0;
    #2 reset = 1;
    #1;
    chk("async_reset_en", 32'(dif.dispatch_en), 32'h7);
    chk("async_reset_halted", 32'(dif.halted), 0);
    chk("async_reset_rob_cnt", 32'(rob_cnt), 0);
    chk("async_reset_oth_cnt", 32'(oth_cnt), 0);
    m_state = 0; m_cnt = 0; m_rob = 0; m_oth = 0;
    @(negedge clock); reset = 0;
    @(posedge clock); #1;

    for (int k = 0; k < SAT + 4; k++)
      step(0, 3'b111, 3'b000, 3'b000, 3'b000, 2, 3, 3, 3, 3'b011);
    chk("rob_cnt_saturated", 32'(rob_cnt), SAT);

    for (int k = 0; k < 80; k++)
      step($urandom_range(0, 7) == 0, 3'($urandom), 3'($urandom), 3'($urandom),
           ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
